// File: rtl/drops_step_ctrl.sv
// drops_step_ctrl: game sequencer issuing timed step enables with handshake, moves, pause, abort and level speed-up
module drops_step_ctrl #(
  parameter int TW        = 20,
  parameter int TICK_INIT = 1000000,
  parameter int TICK_MIN  = 250000,
  parameter int TICK_STEP = 50000,
  parameter int LVL_STEPS = 32,
  parameter int DONE_TO   = 15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_start_i,
  input  logic       btn_pause_i,
  input  logic       d_act_i,
  output logic       e_act_o,
  output logic       left_o,
  output logic       right_o,
  output logic       game_reset_o,
  output logic [3:0] level_o,
  output logic [1:0] state_o,
  output logic       timeout_o
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_WAIT  = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;
  localparam logic [TW-1:0] T_INIT = TW'(TICK_INIT);
  localparam logic [TW-1:0] T_MIN  = TW'(TICK_MIN);
  localparam logic [TW:0]   T_STEP = (TW+1)'(TICK_STEP);
  localparam logic [7:0]    LVL_N  = 8'(LVL_STEPS);
  localparam logic [7:0]    DTO    = 8'(DONE_TO);
  logic [3:0] s1, s2, s3, ed;
  logic ed_l, ed_r, ed_s, ed_p;
  logic [1:0] state_nx;
  logic [TW-1:0] tick, period, per_dn;
  logic [TW:0] dec;
  logic [7:0] step_cnt, step_nx, wcnt;
  logic pend_l, pend_r, pause_pend;
  logic expire, step, lvl_up, to_hit;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {btn_pause_i, btn_start_i, btn_right_i, btn_left_i};
      s2 <= s1;
      s3 <= s2;
    end
  assign ed = s2 & ~s3;
  assign {ed_p, ed_s, ed_r, ed_l} = ed;
  assign expire  = state_o == S_RUN && tick == period - TW'(1);
  assign step    = expire && !ed_s && !ed_p;
  assign e_act_o = step;
  assign left_o  = step & pend_l & ~pend_r;
  assign right_o = step & pend_r & ~pend_l;
  assign step_nx = step_cnt + 8'd1;
  assign lvl_up  = step_nx == LVL_N;
  assign to_hit  = wcnt + 8'd1 == DTO;
  // period shrink done one bit wider so a large step cannot wrap below the floor
  assign dec     = {1'b0, period} - T_STEP;
  assign per_dn  = (dec[TW] || dec[TW-1:0] < T_MIN) ? T_MIN : dec[TW-1:0];
  always_comb begin
    state_nx = state_o;
    case (state_o)
      S_IDLE:  state_nx = ed_s ? S_RUN : S_IDLE;
      S_RUN:   state_nx = ed_s ? S_IDLE : ed_p ? S_PAUSE : expire ? S_WAIT : S_RUN;
      S_WAIT:  state_nx = ed_s ? S_IDLE : d_act_i ? ((pause_pend | ed_p) ? S_PAUSE : S_RUN) :
                          to_hit ? S_IDLE : S_WAIT;
      default: state_nx = ed_s ? S_IDLE : ed_p ? S_RUN : S_PAUSE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_o      <= S_IDLE;
      game_reset_o <= 1'b1;
      tick         <= '0;
      period       <= '0;
      step_cnt     <= '0;
      wcnt         <= '0;
      level_o      <= '0;
      pend_l       <= 1'b0;
      pend_r       <= 1'b0;
      pause_pend   <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state_o      <= state_nx;
      game_reset_o <= state_nx == S_IDLE;
      if (state_o == S_IDLE && ed_s) begin
        tick       <= '0;
        period     <= T_INIT;
        step_cnt   <= '0;
        wcnt       <= '0;
        level_o    <= '0;
        pend_l     <= 1'b0;
        pend_r     <= 1'b0;
        pause_pend <= 1'b0;
        timeout_o  <= 1'b0;
      end else begin
        // an edge landing in the step cycle survives the clear for the next step
        if (state_o != S_IDLE) begin
          pend_l <= ed_l | (pend_l & ~step);
          pend_r <= ed_r | (pend_r & ~step);
        end
        if (state_o == S_RUN && state_nx == S_RUN) tick <= tick + TW'(1);
        if (step) begin
          tick     <= '0;
          wcnt     <= 8'd1;
          step_cnt <= lvl_up ? 8'd0 : step_nx;
          if (lvl_up) begin
            level_o <= level_o == 4'd15 ? level_o : level_o + 4'd1;
            period  <= per_dn;
          end
        end
        if (state_o == S_WAIT) begin
          wcnt <= wcnt + 8'd1;
          if (ed_p) pause_pend <= 1'b1;
          if (d_act_i) pause_pend <= 1'b0;
          if (state_nx == S_IDLE && !ed_s) timeout_o <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_drops_step_ctrl.sv
// tb_drops_step_ctrl: directed checks of start, steps, moves, speed-up, timeout and pause
module tb_drops_step_ctrl;
  logic clk_i = 1'b0;
  logic reset_i, d_act_i;
  logic [3:0] btn;
  logic e_act_o, left_o, right_o, game_reset_o, timeout_o;
  logic [3:0] level_o;
  logic [1:0] state_o;
  int total = 0, bad = 0;
  int n, cnt;
  int iv [8] = '{8, 9, 7, 7, 5, 5, 5, 5};
  drops_step_ctrl #(.TW(8), .TICK_INIT(8), .TICK_MIN(4), .TICK_STEP(2), .LVL_STEPS(2), .DONE_TO(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .btn_left_i(btn[0]), .btn_right_i(btn[1]), .btn_start_i(btn[2]), .btn_pause_i(btn[3]),
    .d_act_i(d_act_i), .e_act_o(e_act_o), .left_o(left_o), .right_o(right_o),
    .game_reset_o(game_reset_o), .level_o(level_o), .state_o(state_o), .timeout_o(timeout_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic press(input logic [3:0] m);
    btn = m;
    cyc();
    btn = '0;
  endtask
  task automatic wait_eact(output int k);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!e_act_o && k < 300);
    chk("eact_seen", e_act_o, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    reset_i = 1'b1;
    btn = '0;
    d_act_i = 1'b1;
    repeat (3) cyc();
    chk("rst_state", state_o, 0);
    chk("rst_grst", game_reset_o, 1);
    chk("rst_eact", e_act_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_timeout", timeout_o, 0);
    reset_i = 1'b0;
    cyc();
    press(4'b0100);
    cyc();
    chk("grst_hold", game_reset_o, 1);
    cyc();
    chk("grst_fall", game_reset_o, 0);
    chk("run_state", state_o, 1);
    wait_eact(n);
    chk("first_step", n + 1, 8);
    cyc();
    chk("wait_state", state_o, 2);
    chk("eact_single", e_act_o, 0);
    cyc();
    cyc();
    @(posedge clk_i);
    #3 reset_i = 1'b1;
    #1;
    chk("arst_state", state_o, 0);
    chk("arst_grst", game_reset_o, 1);
    chk("arst_eact", e_act_o, 0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    cyc();
    press(4'b0100);
    cyc();
    cyc();
    for (int k = 0; k < 8; k++) begin
      wait_eact(n);
      chk("interval", n + 1, iv[k]);
      cyc();
      chk("level", level_o, (k + 1) / 2);
    end
    repeat (60) begin
      wait_eact(n);
      chk("floor_iv", n + 1, 5);
      cyc();
    end
    chk("level_sat", level_o, 15);
    press(4'b0001);
    wait_eact(n);
    chk("left_set", left_o, 1);
    chk("left_no_r", right_o, 0);
    cyc();
    wait_eact(n);
    chk("left_once", left_o, 0);
    cyc();
    press(4'b0011);
    wait_eact(n);
    chk("both_l", left_o, 0);
    chk("both_r", right_o, 0);
    repeat (3) cyc();
    press(4'b0010);
    wait_eact(n);
    chk("r_in_step_n", n, 1);
    chk("r_not_yet", right_o, 0);
    cyc();
    wait_eact(n);
    chk("r_next", right_o, 1);
    chk("r_next_l", left_o, 0);
    d_act_i = 1'b0;
    cyc();
    chk("to_wait1", state_o, 2);
    cyc();
    chk("to_wait2", state_o, 2);
    chk("to_early", timeout_o, 0);
    cyc();
    chk("to_idle", state_o, 0);
    chk("to_flag", timeout_o, 1);
    d_act_i = 1'b1;
    repeat (5) cyc();
    chk("to_sticky", timeout_o, 1);
    chk("to_grst", game_reset_o, 1);
    press(4'b0100);
    cyc();
    cyc();
    chk("to_clear", timeout_o, 0);
    chk("restart_run", state_o, 1);
    repeat (3) cyc();
    press(4'b1000);
    cyc();
    chk("pause_no_eact", e_act_o, 0);
    cyc();
    chk("pause_state", state_o, 3);
    cnt = 0;
    repeat (50) begin
      cyc();
      cnt += int'(e_act_o);
    end
    chk("pause_quiet", cnt, 0);
    chk("pause_hold", state_o, 3);
    press(4'b1000);
    cyc();
    cyc();
    chk("resume_state", state_o, 1);
    wait_eact(n);
    chk("resume_step", n + 1, 3);
    repeat (8) cyc();
    press(4'b1000);
    chk("wp_step", e_act_o, 1);
    d_act_i = 1'b0;
    cyc();
    chk("wp_wait1", state_o, 2);
    cyc();
    chk("wp_wait2", state_o, 2);
    d_act_i = 1'b1;
    cyc();
    chk("wp_pause", state_o, 3);
    chk("wp_no_to", timeout_o, 0);
    press(4'b1000);
    cyc();
    cyc();
    chk("sp_run", state_o, 1);
    press(4'b1100);
    cyc();
    chk("sp_pre", state_o, 1);
    cyc();
    chk("sp_idle", state_o, 0);
    chk("sp_grst", game_reset_o, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
